// File: rtl/audio_dsp_pkg.sv
// Shared constants and helpers for the audio gain datapath.
// Holds the default widths, the unity-gain value and the saturation limits.
package audio_dsp_pkg;

  localparam int DIN_W_DEF  = 24;
  localparam int GAIN_W_DEF = 12;
  localparam int FRAC_W_DEF = 10;
  localparam int NUM_CH_DEF = 2;

  localparam logic [GAIN_W_DEF-1:0] UNITY_GAIN_DEF = GAIN_W_DEF'(1) << FRAC_W_DEF;
  localparam logic [DIN_W_DEF-1:0]  SAT_MAX_DEF    = {1'b0, {(DIN_W_DEF-1){1'b1}}};
  localparam logic [DIN_W_DEF-1:0]  SAT_MIN_DEF    = {1'b1, {(DIN_W_DEF-1){1'b0}}};

  function automatic int chWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

  // Wide forms of the constants; callers slice them down to their own widths.
  function automatic logic [63:0] unityGainVal(input int fracW);
    return 64'd1 << fracW;
  endfunction

  function automatic logic [63:0] satMaxVal(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] satMinVal(input int w);
    return ~satMaxVal(w);
  endfunction

endpackage

// File: rtl/audio_round_sat.sv
// Round-half-up and saturate a signed fixed-point product down to the sample width.
// Purely combinational; the caller registers the result.
module audio_round_sat
  import audio_dsp_pkg::*;
#(
  parameter int IN_W   = 37,
  parameter int FRAC_W = 10,
  parameter int DIN_W  = 24
) (
  input  logic [IN_W-1:0]  i_prod,
  output logic [DIN_W-1:0] o_data,
  output logic             o_sat
);

  localparam int SUM_W = IN_W + 1;
  localparam int RND_W = SUM_W - FRAC_W;
  localparam logic [SUM_W-1:0] HALF    = SUM_W'(1) << (FRAC_W - 1);
  localparam logic [63:0]      MAX_W   = satMaxVal(DIN_W);
  localparam logic [63:0]      MIN_W   = satMinVal(DIN_W);
  localparam logic [DIN_W-1:0] SAT_MAX = MAX_W[DIN_W-1:0];
  localparam logic [DIN_W-1:0] SAT_MIN = MIN_W[DIN_W-1:0];

  logic [SUM_W-1:0]       w_sum;
  logic [RND_W-1:0]       w_rnd;
  logic [RND_W-DIN_W:0]   w_top;
  logic                   w_unusedFrac;

  // One guard bit keeps the rounding add from wrapping; dropping the low
  // FRAC_W bits of a sign-extended value is the arithmetic shift.
  assign w_sum        = {i_prod[IN_W-1], i_prod} + HALF;
  assign w_rnd        = w_sum[SUM_W-1:FRAC_W];
  assign w_top        = w_rnd[RND_W-1:DIN_W-1];
  assign w_unusedFrac = ^w_sum[FRAC_W-1:0];

  // The value fits only when every bit above the output sign bit matches it.
  always_comb begin
    o_sat  = 1'b0;
    o_data = w_rnd[DIN_W-1:0];
    if (!(&w_top) && (|w_top)) begin
      o_sat  = 1'b1;
      o_data = w_rnd[RND_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/audio_gain_mul_pipe.sv
// Per-channel audio gain: 3-stage valid/ready pipeline (lookup, multiply, round/saturate)
// with a writable gain table that resets to unity.
module audio_gain_mul_pipe
  import audio_dsp_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CH_W   = chWidth(NUM_CH)
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIN_W-1:0]  in_data,
  input  logic [CH_W-1:0]   in_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIN_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_ch,
  output logic              out_sat,
  input  logic              gain_wr_en,
  input  logic [CH_W-1:0]   gain_wr_ch,
  input  logic [GAIN_W-1:0] gain_wr_data
);

  localparam int PROD_W = DIN_W + GAIN_W + 1;
  localparam logic [63:0]       UNITY_W = unityGainVal(FRAC_W);
  localparam logic [GAIN_W-1:0] UNITY   = UNITY_W[GAIN_W-1:0];

  logic              r_runEn;
  logic [GAIN_W-1:0] r_gain [NUM_CH];

  logic              r_s1Valid;
  logic [DIN_W-1:0]  r_s1Data;
  logic [CH_W-1:0]   r_s1Ch;
  logic [GAIN_W-1:0] r_s1Gain;

  logic              r_s2Valid;
  logic [PROD_W-1:0] r_s2Prod;
  logic [CH_W-1:0]   r_s2Ch;

  logic              r_s3Valid;
  logic [DIN_W-1:0]  r_s3Data;
  logic [CH_W-1:0]   r_s3Ch;
  logic              r_s3Sat;

  logic              w_s1Adv;
  logic              w_s2Adv;
  logic              w_s3Adv;
  logic              w_inFire;
  logic [GAIN_W-1:0] w_gainSel;
  logic [PROD_W-1:0] w_dataExt;
  logic [PROD_W-1:0] w_gainExt;
  logic [PROD_W-1:0] w_prod;
  logic [DIN_W-1:0]  w_rsData;
  logic              w_rsSat;

  assign w_s3Adv  = !r_s3Valid || out_ready;
  assign w_s2Adv  = !r_s2Valid || w_s3Adv;
  assign w_s1Adv  = !r_s1Valid || w_s2Adv;
  assign in_ready = r_runEn && w_s1Adv;
  assign w_inFire = in_valid && in_ready;

  assign out_valid = r_s3Valid;
  assign out_data  = r_s3Data;
  assign out_ch    = r_s3Ch;
  assign out_sat   = r_s3Sat;

  // Holds in_ready low until the first clock edge after reset is released.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_runEn <= 1'b0;
    else           r_runEn <= 1'b1;
  end

  // Channels with no table entry never match and so read back as gain 0.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_gain[i] <= UNITY;
    end else if (gain_wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (gain_wr_ch == CH_W'(i)) r_gain[i] <= gain_wr_data;
      end
    end
  end

  always_comb begin
    w_gainSel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_ch == CH_W'(i)) w_gainSel = r_gain[i];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s1Valid <= 1'b0;
      r_s1Data  <= '0;
      r_s1Ch    <= '0;
      r_s1Gain  <= '0;
    end else if (w_s1Adv) begin
      r_s1Valid <= w_inFire;
      if (w_inFire) begin
        r_s1Data <= in_data;
        r_s1Ch   <= in_ch;
        r_s1Gain <= w_gainSel;
      end
    end
  end

  // Gain is zero-extended so it is never read as negative.
  assign w_dataExt = {{(GAIN_W+1){r_s1Data[DIN_W-1]}}, r_s1Data};
  assign w_gainExt = {{DIN_W{1'b0}}, 1'b0, r_s1Gain};
  assign w_prod    = $signed(w_dataExt) * $signed(w_gainExt);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Prod  <= '0;
      r_s2Ch    <= '0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Prod <= w_prod;
        r_s2Ch   <= r_s1Ch;
      end
    end
  end

  audio_round_sat #(
    .IN_W   (PROD_W),
    .FRAC_W (FRAC_W),
    .DIN_W  (DIN_W)
  ) u_roundSat (
    .i_prod (r_s2Prod),
    .o_data (w_rsData),
    .o_sat  (w_rsSat)
  );

  // Output registers load only on advance, so they stay frozen during a stall.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_s3Valid <= 1'b0;
      r_s3Data  <= '0;
      r_s3Ch    <= '0;
      r_s3Sat   <= 1'b0;
    end else if (w_s3Adv) begin
      r_s3Valid <= r_s2Valid;
      if (r_s2Valid) begin
        r_s3Data <= w_rsData;
        r_s3Ch   <= r_s2Ch;
        r_s3Sat  <= w_rsSat;
      end
    end
  end

endmodule

// File: tb/tb_audio_gain_mul_pipe.sv
// Directed self-checking bench for audio_gain_mul_pipe at default parameters.
// Expected values are hand-computed from gain * sample / 1024 with round-half-up.
module tb_audio_gain_mul_pipe;

  localparam int DIN_W  = 24;
  localparam int GAIN_W = 12;
  localparam int CH_W   = 1;

  logic              ap_clk;
  logic              ap_rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  in_data;
  logic [CH_W-1:0]   in_ch;
  logic              out_valid;
  logic              out_ready;
  logic [DIN_W-1:0]  out_data;
  logic [CH_W-1:0]   out_ch;
  logic              out_sat;
  logic              gain_wr_en;
  logic [CH_W-1:0]   gain_wr_ch;
  logic [GAIN_W-1:0] gain_wr_data;

  int vecCount = 0;
  int errCount = 0;

  audio_gain_mul_pipe dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ch        (in_ch),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .out_sat      (out_sat),
    .gain_wr_en   (gain_wr_en),
    .gain_wr_ch   (gain_wr_ch),
    .gain_wr_data (gain_wr_data)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one sample and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [DIN_W-1:0] data, input logic [CH_W-1:0] ch);
    int n = 0;
    @(negedge ap_clk);
    in_valid = 1'b1;
    in_data  = data;
    in_ch    = ch;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic writeGain(input logic [CH_W-1:0] ch, input logic [GAIN_W-1:0] val);
    @(negedge ap_clk);
    gain_wr_en   = 1'b1;
    gain_wr_ch   = ch;
    gain_wr_data = val;
    @(posedge ap_clk);
    #1;
    gain_wr_en = 1'b0;
  endtask

  // Single sample through an idle pipeline; also checks the 3-cycle latency.
  task automatic runOne(input string tag, input logic [DIN_W-1:0] data, input logic [CH_W-1:0] ch,
                        input logic [DIN_W-1:0] expData, input logic expSat);
    int lat;
    applyStimulus(data, ch);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, 32'd3);
    checkOutput({tag, "_data"}, {8'd0, out_data}, {8'd0, expData});
    checkOutput({tag, "_sat"}, {31'd0, out_sat}, {31'd0, expSat});
    checkOutput({tag, "_ch"}, {31'd0, out_ch}, {31'd0, ch});
    @(posedge ap_clk);
    #1;
  endtask

  logic [DIN_W-1:0] bpData [20];

  initial begin
    int tx, rx, cyc, got, n, stale;
    logic stallPrev, sawFull;
    logic [DIN_W-1:0] heldData;

    ap_rst_n     = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_ch        = '0;
    out_ready    = 1'b1;
    gain_wr_en   = 1'b0;
    gain_wr_ch   = '0;
    gain_wr_data = '0;

    $display("[TB] reset checks");
    repeat (3) @(negedge ap_clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_data", {8'd0, out_data}, 32'd0);
    checkOutput("rst_out_sat", {31'd0, out_sat}, 32'd0);
    checkOutput("rst_out_ch", {31'd0, out_ch}, 32'd0);
    ap_rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge ap_clk);
    #1;
    checkOutput("rel_in_ready_high", {31'd0, in_ready}, 32'd1);

    $display("[TB] unity, saturation and rounding");
    runOne("unity", 24'h123456, 1'b0, 24'h123456, 1'b0);
    writeGain(1'b1, 12'd4095);
    runOne("sat_pos", 24'h7FFFFF, 1'b1, 24'h7FFFFF, 1'b1);
    writeGain(1'b1, 12'd2048);
    runOne("sat_neg", 24'h800000, 1'b1, 24'h800000, 1'b1);
    writeGain(1'b1, 12'd512);
    runOne("rnd_p3", 24'h000003, 1'b1, 24'h000002, 1'b0);
    runOne("rnd_m3", 24'hFFFFFD, 1'b1, 24'hFFFFFF, 1'b0);
    runOne("rnd_p1", 24'h000001, 1'b1, 24'h000001, 1'b0);

    $display("[TB] backpressure");
    for (int i = 0; i < 20; i++) bpData[i] = 24'h010000 + 24'(i * 'h111);
    tx = 0; rx = 0; cyc = 0;
    stallPrev = 1'b0; sawFull = 1'b0; heldData = '0;
    while (rx < 20 && cyc < 200) begin
      @(negedge ap_clk);
      if (stallPrev) begin
        checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("bp_hold_data", {8'd0, out_data}, {8'd0, heldData});
      end
      out_ready = !(cyc >= 8 && cyc < 13);
      if (tx < 20) begin
        in_valid = 1'b1;
        in_data  = bpData[tx];
        in_ch    = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) sawFull = 1'b1;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("bp_out%0d", rx), {8'd0, out_data}, {8'd0, bpData[rx]});
        rx++;
      end
      if (in_valid && in_ready) tx++;
      stallPrev = out_valid && !out_ready;
      heldData  = out_data;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_count", rx, 32'd20);
    checkOutput("bp_in_ready_full", {31'd0, sawFull}, 32'd1);

    $display("[TB] gain update alongside a sample");
    @(negedge ap_clk);
    gain_wr_en   = 1'b1;
    gain_wr_ch   = 1'b0;
    gain_wr_data = 12'd0;
    in_valid     = 1'b1;
    in_data      = 24'h0ABCDE;
    in_ch        = 1'b0;
    #1;
    checkOutput("gu_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge ap_clk);
    #1;
    gain_wr_en = 1'b0;
    in_data    = 24'h123456;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    got = 0; n = 0;
    while (got < 2 && n < 20) begin
      if (out_valid) begin
        if (got == 0) begin
          checkOutput("gu_first_data", {8'd0, out_data}, 32'h000ABCDE);
        end else begin
          checkOutput("gu_second_data", {8'd0, out_data}, 32'd0);
          checkOutput("gu_second_sat", {31'd0, out_sat}, 32'd0);
        end
        got++;
      end
      @(posedge ap_clk);
      #1;
      n++;
    end
    checkOutput("gu_count", got, 32'd2);

    $display("[TB] reset mid-stream");
    @(negedge ap_clk);
    in_valid = 1'b1;
    in_data  = 24'h000100;
    in_ch    = 1'b1;
    @(posedge ap_clk);
    #1;
    in_data = 24'h000200;
    @(posedge ap_clk);
    #1;
    in_data = 24'h000300;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    checkOutput("mid_inflight", {31'd0, out_valid}, 32'd1);
    ap_rst_n = 1'b0;
    #1;
    checkOutput("mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("mid_out_data", {8'd0, out_data}, 32'd0);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    checkOutput("mid_rel_low", {31'd0, in_ready}, 32'd0);
    @(posedge ap_clk);
    #1;
    checkOutput("mid_rel_high", {31'd0, in_ready}, 32'd1);
    stale = 0;
    repeat (6) begin
      if (out_valid) stale++;
      @(posedge ap_clk);
      #1;
    end
    checkOutput("mid_stale", stale, 32'd0);
    runOne("mid_gain0", 24'h000400, 1'b0, 24'h000400, 1'b0);
    runOne("mid_gain1", 24'h000003, 1'b1, 24'h000003, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
